sad_min_tracker: RTL
====================

Name: sad_min_tracker

Overview:
- Stage directly downstream of the WB→SAD pipeline register.
- Each valid cycle it receives a 16-element candidate window (a1..a16) with its col/row.
- Computes the sum of absolute differences (SAD) against a 16-entry template through a 3-stage pipeline.
- Tracks the minimum SAD and its coordinates across a frame; reports the result when the frame's last window drains.

Parameters:
- DATA_W, 32, width of each window/template element (unsigned).
- COORD_W, 6, width of col/row.
- SAD_W, DATA_W+4, SAD width; holds 16 × (2^DATA_W − 1) without overflow.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  reset, synchronous, active-low.
- Start  in  1  begin a new frame; clears min tracking and flushes the pipeline.
- Tmpl_Wr  in  1  template write strobe.
- Tmpl_Idx  in  4  template entry index 0..15.
- Tmpl_Data  in  DATA_W  template entry value.
- Wb_Sad_ReadSp  in  1  window valid.
- Frame_Last  in  1  qualifies the valid window as the frame's last.
- col, row  in  COORD_W each  window coordinates.
- a1..a16  in  DATA_W each  window elements; aK is paired with template entry K−1.
- Busy  out  1  high in RUN.
- Done  out  1  one-cycle pulse: frame result final.
- Min_Sad  out  SAD_W  smallest SAD seen this frame.
- Min_Col, Min_Row  out  COORD_W each  coordinates of Min_Sad.
- Min_Valid  out  1  at least one window was compared this frame.

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - State = IDLE.
  - Busy=0, Done=0, Min_Valid=0.
  - Min_Sad = all ones; Min_Col = 0; Min_Row = 0.
  - All pipeline valid bits = 0; template entries = 0.
  - Reset has priority over every other input, including mid-frame; in-flight windows are discarded.
- FSM states: IDLE, RUN, DONE.
  - IDLE → RUN on Start.
  - RUN → DONE on the cycle the Frame_Last window exits stage 3.
  - DONE → RUN on Start.
  - Start in RUN restarts the frame: remains RUN, pipeline flushed, min cleared.
- Template:
  - Tmpl_Wr writes Tmpl_Data to entry Tmpl_Idx at the edge, only in IDLE or DONE.
  - Writes in RUN are ignored.
  - Writes on the same cycle as Start complete (the state is still IDLE/DONE at that edge).
- Input acceptance: a window is accepted when Wb_Sad_ReadSp=1 and the FSM is in RUN, or Start=1 (the window on the Start cycle belongs to the new frame). Otherwise it is ignored.
- Pipeline (latency 3 edges from accept to compare):
  - S1: 16 registered |aK − T[K−1]|, unsigned, DATA_W bits.
  - S2: four registered partial sums of 4, DATA_W+2 bits.
  - S3: registered total, SAD_W bits.
  - col, row and Frame_Last travel with each window.
  - Each stage has its own valid bit; there is no back-pressure, so a new window is accepted every cycle.
- Compare (on the edge after S3 holds a valid window):
  - If S3 SAD < Min_Sad, or Min_Valid=0: load Min_Sad/Min_Col/Min_Row and set Min_Valid=1.
  - Ties keep the earlier window (strict less-than).
- Done:
  - Pulses for exactly one cycle, the cycle after the Frame_Last window's compare.
  - Min outputs already include that window's compare when Done pulses.
  - Min outputs then hold until the next Start or reset.
- Start:
  - Clears Min_Valid, sets Min_Sad to all ones, clears S1–S3 valid bits (old-frame windows are dropped), suppresses any pending Done.
  - Min_Col/Min_Row are unchanged by Start.
- Frame_Last with no valid window has no effect.
- A frame with zero windows never reaches DONE.

Optional Feature:
- SAD_DEBUG_OUT_EN defined: adds output ports Cur_Valid (1), Cur_Sad (SAD_W), Cur_Col and Cur_Row (COORD_W). These are driven directly from the S3 registers for every window, and are 0 after reset and after a Start flush.
- SAD_DEBUG_OUT_EN undefined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset, load T[i]=i; Start, then one window aK=K−1 at (3,5) with Frame_Last=1 → Done pulses at accept+4 edges; Min_Sad=0, Min_Col=3, Min_Row=5, Min_Valid=1.
- T=0; Start, then back-to-back windows with all aK=10 (SAD 160) at (1,1), all 2 (SAD 32) at (2,2), all 2 at (4,4), all 7 with Frame_Last → Min_Sad=32 at (2,2) (tie does not update); exactly one Done pulse.
- T=0; one window with all aK=0xFFFFFFFF → Min_Sad=0xF_FFFFFFF0 (16 × (2^32−1)); no overflow.
- Tmpl_Wr during RUN with Idx=0, Data=100 → template unchanged; a window with a1=100, others=0 yields SAD=100, not 0.
- Two windows accepted, then Start before they drain → no Done; Min_Valid=0 until the new frame's first compare; old SADs never appear.
- Rst_n=0 for one cycle mid-frame with 3 windows in flight → next cycle Busy=0, Min_Valid=0, no Done; Start then re-runs a frame correctly with the template reset to 0.

Source files
------------

// File: rtl/sad_min_tracker.sv
// sad_min_tracker: 3-stage SAD pipeline against a 16-entry template, tracking the per-frame minimum and its coordinates.
// Optional debug outputs (Cur_Valid/Cur_Sad/Cur_Col/Cur_Row) are present when SAD_DEBUG_OUT_EN is defined.
module sad_min_tracker #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 6,
  parameter int SAD_W   = DATA_W + 4
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Start,
  input  logic               Tmpl_Wr,
  input  logic [3:0]         Tmpl_Idx,
  input  logic [DATA_W-1:0]  Tmpl_Data,
  input  logic               Wb_Sad_ReadSp,
  input  logic               Frame_Last,
  input  logic [COORD_W-1:0] col,
  input  logic [COORD_W-1:0] row,
  input  logic [DATA_W-1:0]  a1,
  input  logic [DATA_W-1:0]  a2,
  input  logic [DATA_W-1:0]  a3,
  input  logic [DATA_W-1:0]  a4,
  input  logic [DATA_W-1:0]  a5,
  input  logic [DATA_W-1:0]  a6,
  input  logic [DATA_W-1:0]  a7,
  input  logic [DATA_W-1:0]  a8,
  input  logic [DATA_W-1:0]  a9,
  input  logic [DATA_W-1:0]  a10,
  input  logic [DATA_W-1:0]  a11,
  input  logic [DATA_W-1:0]  a12,
  input  logic [DATA_W-1:0]  a13,
  input  logic [DATA_W-1:0]  a14,
  input  logic [DATA_W-1:0]  a15,
  input  logic [DATA_W-1:0]  a16,
  output logic               Busy,
  output logic               Done,
  output logic [SAD_W-1:0]   Min_Sad,
  output logic [COORD_W-1:0] Min_Col,
  output logic [COORD_W-1:0] Min_Row,
  output logic               Min_Valid
`ifdef SAD_DEBUG_OUT_EN
  ,
  output logic               Cur_Valid,
  output logic [SAD_W-1:0]   Cur_Sad,
  output logic [COORD_W-1:0] Cur_Col,
  output logic [COORD_W-1:0] Cur_Row
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [DATA_W-1:0] tmpl [16];
  logic [DATA_W-1:0] win [16];
  logic [DATA_W-1:0] s1_d [16];
  logic [DATA_W+1:0] s2_p [4];
  logic [SAD_W-1:0] s3_sad;
  logic [COORD_W-1:0] s1_col, s1_row, s2_col, s2_row, s3_col, s3_row;
  logic s1_v, s2_v, s3_v, s1_l, s2_l, s3_l, done_pend;
  logic accept, cmp;
  assign win = '{a1, a2, a3, a4, a5, a6, a7, a8, a9, a10, a11, a12, a13, a14, a15, a16};
  assign accept = Start | (Wb_Sad_ReadSp & (state == RUN));
  // A Start edge discards whatever sits in S3, so it never reaches the tracker.
  assign cmp = s3_v & (state == RUN) & ~Start;
`ifdef SAD_DEBUG_OUT_EN
  assign Cur_Valid = s3_v;
  assign Cur_Sad = s3_sad;
  assign Cur_Col = s3_col;
  assign Cur_Row = s3_row;
`endif
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 16; i++)
      s1_d[i] <= (win[i] >= tmpl[i]) ? win[i] - tmpl[i] : tmpl[i] - win[i];
    for (int j = 0; j < 4; j++)
      s2_p[j] <= {2'b0, s1_d[4*j]} + {2'b0, s1_d[4*j+1]} + {2'b0, s1_d[4*j+2]} + {2'b0, s1_d[4*j+3]};
    s1_col <= col;
    s1_row <= row;
    s1_l <= Frame_Last;
    s2_col <= s1_col;
    s2_row <= s1_row;
    s2_l <= s1_l;
    s3_l <= s2_l;
  end
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= IDLE;
      Busy <= 1'b0;
      Done <= 1'b0;
      done_pend <= 1'b0;
      Min_Valid <= 1'b0;
      Min_Sad <= '1;
      Min_Col <= '0;
      Min_Row <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s3_sad <= '0;
      s3_col <= '0;
      s3_row <= '0;
      for (int i = 0; i < 16; i++) tmpl[i] <= '0;
    end else begin
      if (Tmpl_Wr && state != RUN) tmpl[Tmpl_Idx] <= Tmpl_Data;
      s1_v <= accept;
      s2_v <= s1_v & ~Start;
      s3_v <= s2_v & ~Start;
      s3_sad <= Start ? '0 : SAD_W'(s2_p[0]) + SAD_W'(s2_p[1]) + SAD_W'(s2_p[2]) + SAD_W'(s2_p[3]);
      s3_col <= Start ? '0 : s2_col;
      s3_row <= Start ? '0 : s2_row;
      Done <= done_pend & ~Start;
      done_pend <= cmp & s3_l;
      if (Start) begin
        state <= RUN;
        Busy <= 1'b1;
        Min_Valid <= 1'b0;
        Min_Sad <= '1;
      end else if (cmp) begin
        if (!Min_Valid || s3_sad < Min_Sad) begin
          Min_Sad <= s3_sad;
          Min_Col <= s3_col;
          Min_Row <= s3_row;
          Min_Valid <= 1'b1;
        end
        if (s3_l) begin
          state <= DONE;
          Busy <= 1'b0;
        end
      end
    end
  end
endmodule
